// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic-to-binary decode blocks: count width
// helper and the per-sample delta encoding of a signed (+/-) bitstream pair.
package stoch_pkg;

  function automatic int count_width(input int wb);
    return wb + 2;
  endfunction

  typedef enum logic [1:0] {
    DEC_NONE,
    DEC_UP,
    DEC_DOWN
  } dec_e;

  // (p,m)=(1,0) counts up, (0,1) counts down, equal bits cancel
  function automatic dec_e decode(input logic p, input logic m);
    if (p && !m)      return DEC_UP;
    else if (!p && m) return DEC_DOWN;
    else              return DEC_NONE;
  endfunction

endpackage

// File: rtl/stoch_signed_decode_elem.sv
// One matrix element: signed accumulator over the current window of enabled
// samples; acc_next is the running total including this cycle's sample.
module stoch_signed_decode_elem
  import stoch_pkg::*;
#(
  parameter int CW = 10
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          CLR,
  input  logic          p,
  input  logic          m,
  input  logic          last,
  output logic [CW-1:0] acc_next
);

  logic [CW-1:0] acc;
  logic [CW-1:0] delta;
  dec_e          dec;

  always_comb begin
    dec = decode(p, m);
    case (dec)
      DEC_UP:   delta = CW'(1);
      DEC_DOWN: delta = '1;
      default:  delta = '0;
    endcase
    acc_next = acc + delta;
  end

  // The final sample of a window is handed off via acc_next, so acc restarts at 0
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      acc <= '0;
    else if (CLR) acc <= '0;
    else if (EN)  acc <= last ? '0 : acc_next;
  end

endmodule

// File: rtl/stoch_signed_matrix_decode.sv
// Decodes a matrix of signed stochastic bitstream pairs into signed counts,
// one result matrix per window of 2^WINDOW_BITS enabled cycles, valid/ready out.
module stoch_signed_matrix_decode
  import stoch_pkg::*;
#(
  parameter  int NUM_ROWS    = 2,
  parameter  int NUM_COLS    = 2,
  parameter  int WINDOW_BITS = 8,
  localparam int CW          = count_width(WINDOW_BITS)
) (
  input  logic                                       CLK,
  input  logic                                       RST,
  input  logic                                       EN,
  input  logic                                       CLR,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]          Y_p,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]          Y_m,
  output logic                                       VALID,
  input  logic                                       READY,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][CW-1:0]  Y_OUT,
  output logic                                       OVERRUN
);

  logic [WINDOW_BITS-1:0]                     win_cnt;
  logic                                       last;
  logic                                       complete;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][CW-1:0]  acc_bank;

  assign last     = (win_cnt == '1);
  assign complete = EN && last;

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      stoch_signed_decode_elem #(
        .CW (CW)
      ) u_elem (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .CLR      (CLR),
        .p        (Y_p[r][c]),
        .m        (Y_m[r][c]),
        .last     (last),
        .acc_next (acc_bank[r][c])
      );
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      win_cnt <= '0;
      VALID   <= 1'b0;
      OVERRUN <= 1'b0;
      Y_OUT   <= '0;
    end else if (CLR) begin
      win_cnt <= '0;
      VALID   <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      if (EN) win_cnt <= win_cnt + 1'b1;
      if (complete) begin
        Y_OUT <= acc_bank;
        VALID <= 1'b1;
        // Only an unconsumed result being replaced counts as an overrun
        if (VALID && !READY) OVERRUN <= 1'b1;
      end else if (VALID && READY) begin
        VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stoch_signed_matrix_decode.sv
// Directed bench for stoch_signed_matrix_decode with WINDOW_BITS=4 (N=16), 2x2.
module tb_stoch_signed_matrix_decode;

  localparam int R  = 2;
  localparam int C  = 2;
  localparam int WB = 4;
  localparam int CW = WB + 2;

  logic                       CLK = 1'b0;
  logic                       RST;
  logic                       EN;
  logic                       CLR;
  logic [R-1:0][C-1:0]        Y_p;
  logic [R-1:0][C-1:0]        Y_m;
  logic                       VALID;
  logic                       READY;
  logic [R-1:0][C-1:0][CW-1:0] Y_OUT;
  logic                       OVERRUN;

  int tests = 0;
  int fails = 0;
  int completions;

  stoch_signed_matrix_decode #(
    .NUM_ROWS    (R),
    .NUM_COLS    (C),
    .WINDOW_BITS (WB)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .CLR     (CLR),
    .Y_p     (Y_p),
    .Y_m     (Y_m),
    .VALID   (VALID),
    .READY   (READY),
    .Y_OUT   (Y_OUT),
    .OVERRUN (OVERRUN)
  );

  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_y(input string tag, input int r, input int c, input int exp);
    logic signed [31:0] v;
    v = $signed(Y_OUT[r][c]);
    check($sformatf("%s[%0d][%0d]", tag, r, c), v, exp);
  endtask

  task automatic check_all(input string tag, input int exp);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        check_y(tag, r, c, exp);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; CLR = 1'b0; READY = 1'b0; Y_p = '0; Y_m = '0;
    run(2);
    check("rst_valid", VALID, 0);
    check("rst_overrun", OVERRUN, 0);
    check_all("rst_y", 0);
    RST = 1'b0;
    tick();

    // 1: all +1 for a full window, then all -1
    READY = 1'b1; EN = 1'b1; Y_p = '1; Y_m = '0;
    run(15);
    check("t1_valid_before", VALID, 0);
    tick();
    check("t1_valid", VALID, 1);
    check_all("t1_pos", 16);
    Y_p = '0; Y_m = '1;
    tick();
    check("t1_consumed", VALID, 0);
    check_all("t1_hold", 16);
    run(15);
    check("t1_valid2", VALID, 1);
    check_all("t1_neg", -16);

    // 2: cancelling pair on [0][0]; 12 up / 4 down on [1][1]; others idle
    for (int i = 0; i < 16; i++) begin
      Y_p = '0; Y_m = '0;
      Y_p[0][0] = 1'b1; Y_m[0][0] = 1'b1;
      Y_p[1][1] = (i < 12); Y_m[1][1] = (i >= 12);
      tick();
    end
    check("t2_valid", VALID, 1);
    check_y("t2_y", 0, 0, 0);
    check_y("t2_y", 0, 1, 0);
    check_y("t2_y", 1, 0, 0);
    check_y("t2_y", 1, 1, 8);
    check("t2_overrun", OVERRUN, 0);

    // 3: EN at 50% duty for 32 cycles, exactly one completion
    Y_p = '1; Y_m = '0;
    completions = 0;
    for (int i = 0; i < 32; i++) begin
      logic prev;
      prev = VALID;
      EN = (i % 2 == 0);
      tick();
      if (i > 0 && !prev && VALID) completions++;
      if (i == 29) check("t3_valid_before", VALID, 0);
      if (i == 30) begin
        check("t3_valid", VALID, 1);
        check_all("t3_y", 16);
      end
    end
    check("t3_completions", completions, 1);
    check("t3_consumed", VALID, 0);

    // 4: two completions with READY low -> overrun, then CLR
    READY = 1'b0; EN = 1'b1;
    Y_p = '1; Y_m = '0; run(4);
    Y_p = '0; Y_m = '0; run(12);
    check("t4_valid1", VALID, 1);
    check_all("t4_first", 4);
    check("t4_no_overrun", OVERRUN, 0);
    Y_p = '0; Y_m = '1; run(6);
    Y_p = '0; Y_m = '0; run(10);
    check("t4_valid2", VALID, 1);
    check_all("t4_second", -6);
    check("t4_overrun", OVERRUN, 1);
    Y_p = '1; Y_m = '0; run(3);
    check("t4_held", VALID, 1);
    CLR = 1'b1; tick(); CLR = 1'b0;
    check("t4_clr_valid", VALID, 0);
    check("t4_clr_overrun", OVERRUN, 0);
    check_all("t4_clr_y", -6);

    // 5: READY high on the completion edge while VALID=1
    Y_p = '1; Y_m = '0; run(2);
    Y_p = '0; run(14);
    check("t5_valid1", VALID, 1);
    check_all("t5_first", 2);
    Y_p = '1; run(3);
    Y_p = '0; run(12);
    READY = 1'b1; tick();
    check("t5_valid2", VALID, 1);
    check_all("t5_second", 3);
    check("t5_overrun", OVERRUN, 0);

    // 6: reset mid-window discards the partial window
    Y_p = '1; Y_m = '0; run(9);
    RST = 1'b1; #1;
    check("t6_rst_valid", VALID, 0);
    check("t6_rst_overrun", OVERRUN, 0);
    check_all("t6_rst_y", 0);
    tick();
    RST = 1'b0;
    run(15);
    check("t6_valid_before", VALID, 0);
    tick();
    check("t6_valid", VALID, 1);
    check_all("t6_y", 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
